instr_fetch: RTL and testbench

- Upstream neighbour of the instruction decoder.
- Holds the program counter and fetches 32-bit words from instruction memory through a req/ack handshake.
- Presents one registered instruction plus its PC to the decoder under a valid/stall handshake.
- Accepts redirects (branch/jump resolution) and flushes stale fetches.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_next_pc.sv | 41 ++++
 rtl/instr_fetch.sv | 149 ++++++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Opcode and field constants plus the fetch-state type, shared by fetch and decode.
// Jump predecode in fetch is enabled by defining JUMP_PREDECODE_EN.
package mips_pkg;

    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam int         OPCODE_MSB = 31;
    localparam int         OPCODE_LSB = 26;
    localparam int         TARGET_W   = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    function automatic logic is_jump(input logic [31:0] word);
        return (word[OPCODE_MSB:OPCODE_LSB] == OP_J) || (word[OPCODE_MSB:OPCODE_LSB] == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect, predecoded jump, pc+4, or hold.
// The predecoded-jump path exists only when JUMP_PREDECODE_EN is defined.
module fetch_next_pc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef JUMP_PREDECODE_EN
    input  logic [31:0]       fetch_word,
`endif
    input  logic              advance,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] seq_pc;

    assign pc_plus4 = pc + ADDR_W'(4);

`ifdef JUMP_PREDECODE_EN
    // j/jal target keeps the upper bits of the delay-slot address
    assign seq_pc = is_jump(fetch_word)
                  ? {pc_plus4[ADDR_W-1:TARGET_W+2], fetch_word[TARGET_W-1:0], 2'b00}
                  : pc_plus4;
`else
    assign seq_pc = pc_plus4;
`endif

    always_comb begin
        next_pc = pc;
        if (redirect_valid) begin
            next_pc = redirect_pc & ~ADDR_W'(3);
        end else if (advance) begin
            next_pc = seq_pc;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, imem req/ack handshake, one-entry output slot to the decoder.
// Optional jump predecode via JUMP_PREDECODE_EN (see fetch_next_pc).
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] instr_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] old_addr_q, old_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              consume;
    logic              slot_free;
    logic              take_ack;

    assign consume   = instr_valid_q && !stall;
    assign slot_free = !instr_valid_q || consume;
    assign take_ack  = (state_q == BUSY) && imem_ack;

    fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef JUMP_PREDECODE_EN
        .fetch_word     (imem_rdata),
`endif
        .advance        (take_ack),
        .next_pc        (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (redirect_valid || slot_free) state_d = BUSY;
            BUSY: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? BUSY : FLUSH;
                end else if (imem_ack) begin
                    state_d = slot_free ? BUSY : IDLE;
                end
            end
            // a further redirect while flushing keeps waiting for the stale ack
            FLUSH: if (imem_ack) state_d = BUSY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            BUSY:  imem_req = 1'b1;
            FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = old_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // An ack that lands on a held slot is parked in the skid entry; requests stop until it drains.
    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        old_addr_d    = old_addr_q;
        if (redirect_valid) begin
            instr_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
            if ((state_q == BUSY) && !imem_ack) old_addr_d = pc_q;
        end else begin
            if (consume) instr_valid_d = 1'b0;
            if (take_ack) begin
                if (slot_free) begin
                    instr_valid_d = 1'b1;
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = pc_q;
                end
            end else if (skid_valid_q && slot_free) begin
                instr_valid_d = 1'b1;
                instr_d       = skid_instr_q;
                instr_pc_d    = skid_pc_q;
                skid_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
        old_addr_q   <= old_addr_d;
    end

    assign instr_valid = instr_valid_q;
    assign Instruction = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed cycle table, reset-during-request sequence,
// and a randomized run against an in-order fetch-stream reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .Instruction    (instruction),
        .instr_pc       (instr_pc)
    );

`ifdef JUMP_PREDECODE_EN
    localparam logic [31:0] PREDEC_NEXT = 32'h0000_000C;
`else
    localparam logic [31:0] PREDEC_NEXT = 32'h0000_0014;
`endif

    typedef struct {
        logic        stall;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents: fixed words at the directed addresses, hashed elsewhere
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_0000: return 32'h0022_1905;
            32'h0000_0004: return 32'h8C22_0003;
            32'h0000_0010: return 32'h0800_0003;
            default: begin
                h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
                if ((h[31:26] == 6'd2) || (h[31:26] == 6'd3)) h[31] = 1'b1;
                return h;
            end
        endcase
    endfunction

    // Address of the instruction following word w fetched from pc
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
`ifdef JUMP_PREDECODE_EN
        if (((w >> 26) == 32'd2) || ((w >> 26) == 32'd3))
            return ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
`endif
        return pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic st, input logic ack, input logic rd, input logic [31:0] rpc,
                       input logic req, input logic [31:0] addr, input logic vld,
                       input logic [31:0] ins, input logic [31:0] ipc);
        vec_t v;
        v.stall = st; v.ack = ack; v.redir = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.vld = vld; v.instr = ins; v.ipc = ipc;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        pend, hold, prev_redir;
    logic [31:0] pend_addr, prev_instr, prev_pc, exp_pc, rpc;
    int          lat, delivered;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_instr", instruction, 32'h0);
        check("reset_pc", instr_pc, 32'h0);
        rst_n = 1'b1;

        // Cycle table, zero-wait memory: stream, 3-cycle stall, flush, coincident redirect, wrap, jump
        row(0, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0, 32'h0);
        row(1, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0022_1905, 32'h0);
        row(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0022_1905, 32'h0);
        row(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0022_1905, 32'h0);
        row(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0022_1905, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h8C22_0003, 32'h4);
        row(0, 0, 1, 32'h0000_0103, 1, 32'h0000_000C, 1, word_at(32'h8), 32'h8);
        row(0, 0, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_000C, 0, 32'h0, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0, 32'h0);
        row(0, 1, 1, 32'hFFFF_FFFC, 1, 32'h0000_0104, 1, word_at(32'h100), 32'h100);
        row(0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_0000, 1, word_at(32'hFFFF_FFFC), 32'hFFFF_FFFC);
        row(0, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h0022_1905, 32'h0);
        row(0, 0, 1, 32'h0000_0010, 1, 32'h0000_0004, 0, 32'h0, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0, 32'h0);
        row(0, 1, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0, 32'h0);
        row(0, 0, 0, 32'h0,         1, PREDEC_NEXT,   1, 32'h0800_0003, 32'h10);

        foreach (vecs[i]) begin
            @(negedge clk);
            check($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("row%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].vld});
            if (vecs[i].req) check($sformatf("row%0d_addr", i), imem_addr, vecs[i].addr);
            if (vecs[i].vld) begin
                check($sformatf("row%0d_instr", i), instruction, vecs[i].instr);
                check($sformatf("row%0d_ipc", i), instr_pc, vecs[i].ipc);
            end
            stall          = vecs[i].stall;
            imem_ack       = vecs[i].ack;
            imem_rdata     = word_at(imem_addr);
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
        end

        // Reset in the middle of an outstanding request, then a stale ack right after release
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_req", {31'b0, imem_req}, 32'd0);
        check("midreset_valid", {31'b0, instr_valid}, 32'd0);
        check("midreset_instr", instruction, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("late_ack_req", {31'b0, imem_req}, 32'd1);
        check("late_ack_addr", imem_addr, 32'h0);
        imem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_valid2", {31'b0, instr_valid}, 32'd0);

        // Randomized run against the in-order fetch-stream model
        do_reset();
        exp_pc = 32'h0; pend = 1'b0; hold = 1'b0; prev_redir = 1'b0; delivered = 0; lat = 0;
        prev_instr = 32'h0; prev_pc = 32'h0; pend_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold) begin
                check("hold_valid", {31'b0, instr_valid}, 32'd1);
                check("hold_instr", instruction, prev_instr);
                check("hold_pc", instr_pc, prev_pc);
            end
            if (prev_redir) check("redirect_clears_valid", {31'b0, instr_valid}, 32'd0);

            imem_ack = 1'b0;
            if (imem_req) begin
                if (!pend) begin
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    lat       = int'($urandom_range(0, 3));
                    check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
                end else begin
                    check("addr_stable", imem_addr, pend_addr);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    pend       = 1'b0;
                end else begin
                    lat--;
                end
            end else if (pend) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                pend = 1'b0;
            end

            stall          = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 1) == 0) rpc = $urandom;
            else rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            redirect_pc = rpc;

            if (instr_valid && !stall) begin
                check("stream_instr", instruction, word_at(exp_pc));
                check("stream_pc", instr_pc, exp_pc);
                exp_pc = model_next(exp_pc, word_at(exp_pc));
                delivered++;
            end
            if (redirect_valid) exp_pc = rpc & ~32'h3;

            hold       = instr_valid && stall && !redirect_valid;
            prev_instr = instruction;
            prev_pc    = instr_pc;
            prev_redir = redirect_valid;
        end
        check("progress", {31'b0, (delivered >= 300)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
